// File: rtl/mem_intf_responder_pkg.sv
// mem_intf_responder_pkg: shared memory message types and the lane/byte-enable helpers.
package mem_intf_responder_pkg;

    typedef enum logic {MEM_LOAD = 1'b0, MEM_STORE = 1'b1} mem_op_t;

    localparam logic [1:0] LEN_WORD = 2'd0;
    localparam logic [1:0] LEN_BYTE = 2'd1;
    localparam logic [1:0] LEN_HALF = 2'd2;

    // Halfwords snap to addr[1]; words (and the reserved length) always start at lane 0.
    function automatic logic [1:0] lane_of(input logic [1:0] len, input logic [1:0] a);
        return len == LEN_BYTE ? a : len == LEN_HALF ? {a[1], 1'b0} : 2'b00;
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] len, input logic [1:0] a);
        logic [1:0] l;
        l = lane_of(len, a);
        return len == LEN_BYTE ? 4'b0001 << l : len == LEN_HALF ? 4'b0011 << l : 4'b1111;
    endfunction

    function automatic logic [31:0] store_align(input logic [31:0] d, input logic [1:0] len,
                                                input logic [1:0] a);
        return d << {lane_of(len, a), 3'b000};
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] len,
                                                 input logic [1:0] a);
        logic [31:0] s;
        s = w >> {lane_of(len, a), 3'b000};
        return len == LEN_BYTE ? {24'b0, s[7:0]} : len == LEN_HALF ? {16'b0, s[15:0]} : s;
    endfunction

endpackage

// File: rtl/mem_intf_responder_if.sv
// mem_intf_responder_if: request/response val/rdy bundle between a memory initiator and target.
interface mem_intf_responder_if #(parameter int p_opaq_bits = 8);

    logic                   req_val;
    logic                   req_rdy;
    logic                   req_op;
    logic [p_opaq_bits-1:0] req_opaque;
    logic [31:0]            req_addr;
    logic [1:0]             req_len;
    logic [31:0]            req_data;
    logic                   resp_val;
    logic                   resp_rdy;
    logic                   resp_op;
    logic [p_opaq_bits-1:0] resp_opaque;
    logic [31:0]            resp_addr;
    logic [1:0]             resp_len;
    logic [31:0]            resp_data;

    modport master (
        output req_val, req_op, req_opaque, req_addr, req_len, req_data, resp_rdy,
        input  req_rdy, resp_val, resp_op, resp_opaque, resp_addr, resp_len, resp_data
    );

    modport slave (
        input  req_val, req_op, req_opaque, req_addr, req_len, req_data, resp_rdy,
        output req_rdy, resp_val, resp_op, resp_opaque, resp_addr, resp_len, resp_data
    );

endinterface

// File: rtl/mem_intf_responder_fifo.sv
// mem_intf_responder_fifo: 2-entry val/rdy response FIFO with registered full/empty flags.
module mem_intf_responder_fifo #(
    parameter int p_width = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enq_val,
    output logic               enq_rdy,
    input  logic [p_width-1:0] enq_data,
    output logic               deq_val,
    input  logic               deq_rdy,
    output logic [p_width-1:0] deq_data
);

    logic [p_width-1:0] mem [2];
    logic wp, rp, full, empty, enq, deq;

    assign enq      = enq_val && !full;
    assign deq      = deq_rdy && !empty;
    assign enq_rdy  = !full;
    assign deq_val  = !empty;
    assign deq_data = mem[rp];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= 1'b0;
            rp    <= 1'b0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (enq) wp <= !wp;
            if (deq) rp <= !rp;
            if (enq != deq) begin
                full  <= enq && (!wp == rp);
                empty <= deq && (!rp == wp);
            end
        end
    end

    always_ff @(posedge clk)
        if (enq) mem[wp] <= enq_data;

endmodule

// File: rtl/mem_intf_responder.sv
// mem_intf_responder: word-organised memory target answering MemIntf loads/stores in order.
module mem_intf_responder
    import mem_intf_responder_pkg::*;
#(
    parameter int p_opaq_bits = 8,
    parameter int p_num_words = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_intf_responder_if.slave  mif
);

    localparam int AW = $clog2(p_num_words);
    localparam int RW = 1 + p_opaq_bits + 32 + 2 + 32;

    logic [31:0]            mem [p_num_words];
    logic [AW-1:0]          idx;
    logic [3:0]             be;
    logic [31:0]            wdata;
    logic                   acc, deq, req_rdy;
    logic [1:0]             cred, cred_n;
    logic                   inf_val;
    mem_op_t                inf_op;
    logic [p_opaq_bits-1:0] inf_opaque;
    logic [31:0]            inf_addr, rd_word, inf_data;
    logic [1:0]             inf_len;
    logic [RW-1:0]          inf_pkt, f_data, resp_pkt;
    logic                   f_val, f_enq_rdy, f_enq;

    assign idx   = mif.req_addr[2 +: AW];
    assign be    = byte_en(mif.req_len, mif.req_addr[1:0]);
    assign wdata = store_align(mif.req_data, mif.req_len, mif.req_addr[1:0]);
    assign acc   = mif.req_val && req_rdy;
    assign deq   = mif.resp_val && mif.resp_rdy;

    assign mif.req_rdy = req_rdy;

    always_ff @(posedge clk)
        if (acc && mif.req_op)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];

    always_ff @(posedge clk) begin
        if (acc) begin
            inf_op     <= mem_op_t'(mif.req_op);
            inf_opaque <= mif.req_opaque;
            inf_addr   <= mif.req_addr;
            inf_len    <= mif.req_len;
            rd_word    <= mem[idx];
        end
    end

    // Credits cover FIFO occupancy plus the in-flight slot, so the FIFO can never overflow.
    assign cred_n = cred + {1'b0, acc} - {1'b0, deq};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inf_val <= 1'b0;
            cred    <= 2'd0;
            req_rdy <= 1'b0;
        end else begin
            inf_val <= acc;
            cred    <= cred_n;
            req_rdy <= cred_n < 2'd2;
        end
    end

    assign inf_data = inf_op == MEM_STORE ? 32'd0 : load_extract(rd_word, inf_len, inf_addr[1:0]);
    assign inf_pkt  = {inf_op, inf_opaque, inf_addr, inf_len, inf_data};

    // The in-flight entry bypasses the FIFO only when nothing older is queued and it is taken now.
    assign f_enq = inf_val && f_enq_rdy && !(!f_val && mif.resp_rdy);

    mem_intf_responder_fifo #(.p_width(RW)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .enq_val  (f_enq),
        .enq_rdy  (f_enq_rdy),
        .enq_data (inf_pkt),
        .deq_val  (f_val),
        .deq_rdy  (mif.resp_rdy),
        .deq_data (f_data)
    );

    assign resp_pkt     = f_val ? f_data : inf_pkt;
    assign mif.resp_val = f_val || inf_val;
    assign {mif.resp_op, mif.resp_opaque, mif.resp_addr, mif.resp_len, mif.resp_data} = resp_pkt;

endmodule

// File: tb/tb_mem_intf_responder.sv
// tb_mem_intf_responder: directed checks of ordering, latency, back-pressure, aliasing and reset.
module tb_mem_intf_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mem_intf_responder_if #(.p_opaq_bits(8)) mif ();

    mem_intf_responder #(.p_opaq_bits(8), .p_num_words(256)) dut (
        .clk (clk),
        .rst (rst),
        .mif (mif)
    );

    task automatic send(input logic op, input logic [7:0] opq, input logic [31:0] addr,
                        input logic [1:0] len, input logic [31:0] data, output logic to);
        mif.req_op = op; mif.req_opaque = opq; mif.req_addr = addr;
        mif.req_len = len; mif.req_data = data; mif.req_val = 1'b1;
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (mif.req_rdy) begin
                @(posedge clk); #1;
                to = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        mif.req_val = 1'b0;
    endtask

    task automatic recv(output logic op, output logic [7:0] opq, output logic [31:0] addr,
                        output logic [31:0] data, output logic to);
        op = 1'bx; opq = 'x; addr = 'x; data = 'x; to = 1'b1;
        mif.resp_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (mif.resp_val) begin
                op = mif.resp_op; opq = mif.resp_opaque;
                addr = mif.resp_addr; data = mif.resp_data;
                @(posedge clk); #1;
                to = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        mif.resp_rdy = 1'b0;
    endtask

    task automatic xact(input logic op, input logic [7:0] opq, input logic [31:0] addr,
                        input logic [1:0] len, input logic [31:0] wd,
                        output logic [31:0] rd, output logic [31:0] ra, output logic to);
        logic t1, t2, rop;
        logic [7:0] ropq;
        send(op, opq, addr, len, wd, t1);
        recv(rop, ropq, ra, rd, t2);
        to = t1 || t2;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        tests++;
        if (mif.resp_val !== 1'b0 || mif.req_rdy !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: resp_val=%b req_rdy=%b, want 0 0", mif.resp_val, mif.req_rdy);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (mif.req_rdy !== 1'b1 || mif.resp_val !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: req_rdy=%b resp_val=%b, want 1 0", mif.req_rdy, mif.resp_val);
        end
    endtask

    task automatic test_store_load();
        logic t, op;
        logic [7:0] opq;
        logic [31:0] a, d;
        send(1'b1, 8'h11, 32'h100, 2'd0, 32'hDEADBEEF, t);
        tests++;
        if (t !== 1'b0) begin fails++; $display("FAIL sl_store_accept: timeout=%b want 0", t); end
        send(1'b0, 8'h22, 32'h100, 2'd0, 32'h0, t);
        tests++;
        if (t !== 1'b0) begin fails++; $display("FAIL sl_load_accept: timeout=%b want 0", t); end
        recv(op, opq, a, d, t);
        tests++;
        if (t !== 1'b0 || op !== 1'b1 || opq !== 8'h11 || d !== 32'h0 || a !== 32'h100) begin
            fails++;
            $display("FAIL sl_resp0: to=%b op=%b opq=%h addr=%h data=%h, want 0 1 11 00000100 00000000",
                     t, op, opq, a, d);
        end
        recv(op, opq, a, d, t);
        tests++;
        if (t !== 1'b0 || op !== 1'b0 || opq !== 8'h22 || d !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL sl_resp1: to=%b op=%b opq=%h data=%h, want 0 0 22 deadbeef", t, op, opq, d);
        end
    endtask

    task automatic test_subword();
        logic t;
        logic [31:0] d, a;
        xact(1'b1, 8'h30, 32'h200, 2'd0, 32'h0, d, a, t);
        xact(1'b1, 8'h31, 32'h201, 2'd1, 32'h000000AB, d, a, t);
        tests++;
        if (t !== 1'b0 || d !== 32'h0) begin
            fails++; $display("FAIL sb_store_resp: to=%b data=%h, want 0 00000000", t, d);
        end
        xact(1'b0, 8'h32, 32'h200, 2'd0, 32'h0, d, a, t);
        tests++;
        if (t !== 1'b0 || d !== 32'h0000AB00) begin
            fails++; $display("FAIL sb_load_word: to=%b data=%h, want 0 0000ab00", t, d);
        end
        xact(1'b0, 8'h33, 32'h201, 2'd1, 32'h0, d, a, t);
        tests++;
        if (t !== 1'b0 || d !== 32'h000000AB) begin
            fails++; $display("FAIL sb_load_byte: to=%b data=%h, want 0 000000ab", t, d);
        end
        xact(1'b0, 8'h34, 32'h202, 2'd2, 32'h0, d, a, t);
        tests++;
        if (t !== 1'b0 || d !== 32'h0) begin
            fails++; $display("FAIL sb_load_half: to=%b data=%h, want 0 00000000", t, d);
        end
        xact(1'b0, 8'h35, 32'h203, 2'd2, 32'h0, d, a, t);
        tests++;
        if (t !== 1'b0 || d !== 32'h0) begin
            fails++; $display("FAIL sb_load_half_a0: to=%b data=%h, want 0 00000000", t, d);
        end
    endtask

    task automatic test_back_to_back();
        mif.resp_rdy = 1'b1;
        mif.req_op = 1'b0; mif.req_addr = 32'h100; mif.req_len = 2'd0; mif.req_data = 32'h0;
        mif.req_val = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mif.req_opaque = 8'(i);
            @(posedge clk); #1;
            tests++;
            if (mif.resp_val !== 1'b1 || mif.resp_opaque !== 8'(i) || mif.resp_data !== 32'hDEADBEEF ||
                mif.req_rdy !== 1'b1) begin
                fails++;
                $display("FAIL b2b_%0d: val=%b opq=%h data=%h req_rdy=%b, want 1 %h deadbeef 1",
                         i, mif.resp_val, mif.resp_opaque, mif.resp_data, mif.req_rdy, 8'(i));
            end
        end
        mif.req_val = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (mif.resp_val !== 1'b0) begin
            fails++; $display("FAIL b2b_drained: resp_val=%b want 0", mif.resp_val);
        end
        mif.resp_rdy = 1'b0;
    endtask

    task automatic test_stall();
        int acc = 0;
        int exp = 8'h40;
        logic pre;
        mif.resp_rdy = 1'b0;
        mif.req_op = 1'b0; mif.req_addr = 32'h100; mif.req_len = 2'd0;
        mif.req_opaque = 8'h40; mif.req_val = 1'b1;
        for (int c = 0; c < 5; c++) begin
            pre = mif.req_rdy;
            @(posedge clk); #1;
            if (pre) begin acc++; mif.req_opaque = 8'(8'h40 + acc); end
            if (acc > 0) begin
                tests++;
                if (mif.resp_val !== 1'b1 || mif.resp_opaque !== 8'h40 || mif.resp_data !== 32'hDEADBEEF) begin
                    fails++;
                    $display("FAIL stall_stable_%0d: val=%b opq=%h data=%h, want 1 40 deadbeef",
                             c, mif.resp_val, mif.resp_opaque, mif.resp_data);
                end
            end
        end
        tests++;
        if (acc != 2 || mif.req_rdy !== 1'b0) begin
            fails++; $display("FAIL stall_accepts: accepts=%0d req_rdy=%b, want 2 0", acc, mif.req_rdy);
        end
        mif.resp_rdy = 1'b1;
        for (int c = 0; c < 30 && !(exp == 8'h45 && acc == 5); c++) begin
            if (mif.resp_val) begin
                tests++;
                if (mif.resp_opaque !== 8'(exp)) begin
                    fails++; $display("FAIL stall_order: opq=%h want %h", mif.resp_opaque, 8'(exp));
                end
                exp++;
            end
            pre = mif.req_val && mif.req_rdy;
            @(posedge clk); #1;
            if (pre) begin
                acc++;
                if (acc < 5) mif.req_opaque = 8'(8'h40 + acc);
                else mif.req_val = 1'b0;
            end
        end
        mif.req_val = 1'b0;
        tests++;
        if (exp != 8'h45 || acc != 5 || mif.resp_val !== 1'b0) begin
            fails++;
            $display("FAIL stall_drain: next_opq=%h accepts=%0d resp_val=%b, want 45 5 0",
                     8'(exp), acc, mif.resp_val);
        end
        mif.resp_rdy = 1'b0;
    endtask

    task automatic test_alias();
        logic t;
        logic [31:0] d, a;
        xact(1'b1, 8'h50, 32'h0, 2'd0, 32'h12345678, d, a, t);
        xact(1'b0, 8'h51, 32'h400, 2'd0, 32'h0, d, a, t);
        tests++;
        if (t !== 1'b0 || d !== 32'h12345678 || a !== 32'h400) begin
            fails++; $display("FAIL alias: to=%b data=%h addr=%h, want 0 12345678 00000400", t, d, a);
        end
    endtask

    task automatic test_reset_flush();
        logic t1, t2, seen;
        logic [31:0] d, a;
        mif.resp_rdy = 1'b0;
        send(1'b0, 8'h70, 32'h200, 2'd0, 32'h0, t1);
        send(1'b0, 8'h71, 32'h204, 2'd0, 32'h0, t2);
        tests++;
        if (t1 !== 1'b0 || t2 !== 1'b0 || mif.resp_val !== 1'b1 || mif.req_rdy !== 1'b0) begin
            fails++;
            $display("FAIL rf_buffered: to=%b%b resp_val=%b req_rdy=%b, want 00 1 0",
                     t1, t2, mif.resp_val, mif.req_rdy);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (mif.resp_val !== 1'b0) begin
            fails++; $display("FAIL rf_async_clear: resp_val=%b want 0", mif.resp_val);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        mif.resp_rdy = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (mif.req_rdy !== 1'b1) begin
            fails++; $display("FAIL rf_req_rdy: req_rdy=%b want 1", mif.req_rdy);
        end
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            seen |= mif.resp_val;
            @(posedge clk); #1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++; $display("FAIL rf_no_stale: resp_val seen=%b want 0", seen);
        end
        mif.resp_rdy = 1'b0;
        xact(1'b0, 8'h72, 32'h200, 2'd0, 32'h0, d, a, t1);
        tests++;
        if (t1 !== 1'b0 || d !== 32'h0000AB00) begin
            fails++; $display("FAIL rf_data_kept: to=%b data=%h, want 0 0000ab00", t1, d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mif.req_val = 1'b0; mif.req_op = 1'b0; mif.req_opaque = 8'h0; mif.req_addr = 32'h0;
        mif.req_len = 2'd0; mif.req_data = 32'h0; mif.resp_rdy = 1'b0;
        test_reset();
        test_store_load();
        test_subword();
        test_back_to_back();
        test_stall();
        test_alias();
        test_reset_flush();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
